// File: rtl/dlbf_coeffs_m_axis.sv
// dlbf_coeffs_m_axis
//   Streams beamforming coefficients out of BRAM port B as an AXI4-Stream
//   master. A go rise latches the run parameters and reads niter blocks of
//   block_size words. The address wraps at rollover_addr. Read data lands in a
//   small output FIFO that drives the stream.
//
// Ports
//   m_axis_clk, m_axis_rst_n : clock / asynchronous active-low reset
//   soft_rst                 : synchronous abort, same effect as reset
//   go                       : level, rising edge starts a run
//   niter, block_size        : blocks per run, words per block (latched)
//   rollover_addr            : last valid address before wrapping to 0 (latched)
//   bram_addrb/enb/doutb     : BRAM port-B read interface
//   m_axis_tdata/tvalid/tready/tlast : stream output
//   done                     : run-complete level, cleared when go drops
//   addrb_wire               : registered next read address, for CDC back
module dlbf_coeffs_m_axis #(
  parameter int DATA_WIDTH   = 128,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst_n,
  input  logic                  soft_rst,
  input  logic                  go,
  input  logic [11:0]           niter,
  input  logic [11:0]           block_size,
  input  logic [15:0]           rollover_addr,
  output logic [15:0]           bram_addrb,
  output logic                  bram_enb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  done,
  output logic [15:0]           addrb_wire
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    go_prev_q, go_prev_d;
  logic [11:0]             niter_q, niter_d;
  logic [11:0]             bsize_q, bsize_d;
  logic [15:0]             roll_q, roll_d;
  logic [15:0]             addr_q, addr_d;
  logic [11:0]             word_cnt_q, word_cnt_d;
  logic [11:0]             blk_cnt_q, blk_cnt_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  logic go_rise;
  logic issue;
  logic issue_last;
  logic fifo_wr;
  logic fifo_pop;
  int   inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_axis_tvalid = (fifo_count_q != '0);
  // Head is masked while empty so idle/reset data reads as zero.
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[rd_ptr_q];
  assign bram_enb      = issue;
  assign bram_addrb    = addr_q;
  assign addrb_wire    = addr_q;
  assign done          = done_q;

  always_comb begin
    state_d      = state_q;
    go_prev_d    = go;
    niter_d      = niter_q;
    bsize_d      = bsize_q;
    roll_d       = roll_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    go_rise  = go & ~go_prev_q;
    fifo_pop = m_axis_tvalid & m_axis_tready;
    fifo_wr  = pipe_vld_q[READ_LATENCY-1];

    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + int'(pipe_vld_q[i]);
    end

    // Credit: every outstanding read already owns a FIFO slot.
    issue      = (state_q == S_RUN) && ((int'(fifo_count_q) + inflight) < FIFO_DEPTH);
    issue_last = (word_cnt_q == bsize_q - 12'd1);

    // Valid/last shadow of the BRAM read pipeline.
    pipe_vld_d[0]  = issue;
    pipe_last_d[0] = issue & issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    if (fifo_wr) begin
      fifo_last_d[wr_ptr_q] = pipe_last_q[READ_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (fifo_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    fifo_count_d = fifo_count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);

    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          niter_d    = niter;
          bsize_d    = block_size;
          roll_d     = rollover_addr;
          addr_d     = '0;
          word_cnt_d = '0;
          blk_cnt_d  = '0;
          state_d    = (niter == 12'd0 || block_size == 12'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = (addr_q == roll_q) ? 16'd0 : addr_q + 16'd1;
          if (issue_last) begin
            word_cnt_d = '0;
            blk_cnt_d  = blk_cnt_q + 12'd1;
            if (blk_cnt_q == niter_q - 12'd1) begin
              state_d = S_DRAIN;
            end
          end else begin
            word_cnt_d = word_cnt_q + 12'd1;
          end
        end
      end
      S_DRAIN: begin
        // Pipeline empty and the FIFO either empty or losing its last beat now.
        if (inflight == 0 && fifo_count_q == CNT_W'(fifo_pop)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!go) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // done tracks entry into DONE; an empty run reaches DONE straight from
    // IDLE, and there done lags one cycle so it appears two cycles after go.
    done_d = (state_d == S_DONE) && (state_q != S_IDLE);

    if (soft_rst) begin
      state_d      = S_IDLE;
      go_prev_d    = 1'b0;
      niter_d      = '0;
      bsize_d      = '0;
      roll_d       = '0;
      addr_d       = '0;
      word_cnt_d   = '0;
      blk_cnt_d    = '0;
      pipe_vld_d   = '0;
      pipe_last_d  = '0;
      fifo_last_d  = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      state_q      <= S_IDLE;
      go_prev_q    <= 1'b0;
      niter_q      <= '0;
      bsize_q      <= '0;
      roll_q       <= '0;
      addr_q       <= '0;
      word_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      go_prev_q    <= go_prev_d;
      niter_q      <= niter_d;
      bsize_q      <= bsize_d;
      roll_q       <= roll_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_last_q  <= pipe_last_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      done_q       <= done_d;
    end
  end

  // Payload storage needs no reset: the head is masked until written.
  always_ff @(posedge m_axis_clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= bram_doutb;
    end
  end

endmodule

// File: doc/dlbf_coeffs_m_axis.md
# dlbf_coeffs_m_axis

Streams beamforming coefficients out of the coefficient BRAM (port B) as an AXI4-Stream master, one instance per output stream (m0..m3). Sits in the m_axis_clk domain directly downstream of the coefficient CDC stage. It consumes the synchronized go, soft reset, niter, block_size and rollover_addr, and returns done and its live read address to that stage for crossing back to the BRAM/control clock.

## Interface
- DATA_WIDTH, 128: BRAM word and TDATA width.
- READ_LATENCY, 2: BRAM port-B read latency in cycles (1..3).
- FIFO_DEPTH, 4: output buffer depth. Must be ≥ READ_LATENCY+2.

- m_axis_clk  in  1  clock; all logic on its rising edge.
- m_axis_rst_n  in  1  asynchronous, active-low reset.
- soft_rst  in  1  synchronous, active-high abort/clear. Driven by the synchronized m_axis_rst.
- go  in  1  level. A rising edge starts a run.
- niter  in  12  blocks per run.
- block_size  in  12  words per block.
- rollover_addr  in  16  last valid BRAM address before wrap to 0.
- bram_addrb  out  16  BRAM port-B address.
- bram_enb  out  1  BRAM port-B read enable.
- bram_doutb  in  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after an enb cycle.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the last word of each block.
- done  out  1  run-complete level.
- addrb_wire  out  16  registered copy of the next read address, for CDC back to the control clock.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: waits for a go rise (go=1 with the previous sampled go=0).
  - On a go rise, latch niter, block_size and rollover_addr, set address=0, word count=0, block count=0.
  - Go to RUN. If niter==0 or block_size==0, go straight to DONE instead; no reads, no transfers.
- RUN: issue one read per cycle (bram_enb=1) while fifo_count + inflight < FIFO_DEPTH.
  - Each issued read carries a last flag, set when word count == block_size-1.
  - After each issue, the address advances to addr+1, or to 0 when addr==rollover_addr. The address continues across block boundaries and runs.
  - When the last word of block niter-1 is issued, go to DRAIN.
- DRAIN: no further reads. When the FIFO and the read pipeline are empty and the final beat has been accepted, go to DONE.
- DONE: done=1. Stay until go==0, then done=0 and return to IDLE. A go that stays high never restarts a run.
- FIFO: read data is written READ_LATENCY cycles after enb, together with its last flag. TDATA/TLAST come from the FIFO head, and tvalid = FIFO not empty. The credit rule guarantees it never overflows.
- AXIS rules:
  - tdata and tlast hold stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on reset or soft_rst.
- Input changes: changes to niter, block_size or rollover_addr outside IDLE are ignored. Changes to go during RUN or DRAIN are ignored.
- soft_rst=1 in any state: same effect as reset on the next edge. Outstanding reads are discarded and the FIFO is flushed. This abort is permitted because the downstream is reset together with this block.
- rollover_addr=0: every read uses address 0.
- Counters: 12-bit word and block counters, compared against the latched values. 16-bit address.
- addrb_wire: equals the registered internal next-address. It changes by +1 per issued read, except at a wrap to 0.

## Timing
- Reset values, applied asynchronously on m_axis_rst_n=0 and synchronously on soft_rst:
  - state=IDLE.
  - bram_enb=0, bram_addrb=0, addrb_wire=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - done=0, FIFO empty.
- Start latency: go rise sampled at edge 0 → first bram_enb at cycle 1 → data written to the FIFO at cycle 1+READ_LATENCY → m_axis_tvalid=1 at cycle 2+READ_LATENCY (cycle 4 with the defaults).
- Throughput: with tready held high, one beat per cycle sustained.
- Completion: done rises the cycle after the final beat's handshake.
- Return to IDLE: done falls the cycle after go is sampled low.

## Test plan
- Basic run: niter=2, block_size=4, rollover_addr=15, tready=1 → 8 beats at addresses 0..7 on consecutive cycles, tlast on beats 4 and 8, done=1 one cycle after beat 8, addrb_wire=8.
- Wrap: niter=1, block_size=6, rollover_addr=3 → read addresses 0,1,2,3,0,1; tlast on beat 6 only.
- Backpressure: tready toggling 1,0,0,1 in a repeating pattern with niter=3, block_size=5:
  - 15 beats in order, data held stable while stalled.
  - fifo_count never exceeds FIFO_DEPTH.
  - No beat lost or duplicated.
- Degenerate sizes: niter=0 (then separately block_size=0) → bram_enb never asserted, tvalid never asserted, done=1 at cycle 2; go low → done=0 one cycle later.
- Abort: soft_rst pulse after 3 of 10 beats → next cycle tvalid=0, done=0, state IDLE. A new go rise restarts from address 0 with fresh parameters.
- Async reset mid-stream: m_axis_rst_n low mid-cycle → all outputs at reset values immediately, without waiting for a clock edge. Parameter changes and a held-high go during RUN have no effect.
